// File: rtl/shifter_ctrl.sv
// shifter_ctrl
// Sequencer around an external combinational barrel shifter. It implements
// the ARM-style register-specified shift rules: LSL, LSR, ASR, ROR and RRX,
// each with a shift amount of 0-255, and produces the carry-out.
//
// A request is accepted in IDLE and its operands are registered. The sh_*
// outputs are loaded at the same edge, so they stay glitch-free while the
// shifter settles in SHIFT. The result is captured at the end of SHIFT and
// is held in DONE until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer must hold valid and its payload until that edge.
// req_ready is high only in IDLE. rsp_valid is high only in DONE, and
// rsp_y/rsp_cout stay constant there until rsp_ready is seen.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   req_valid/req_ready     request handshake
//   req_op                  0=LSL 1=LSR 2=ASR 3=ROR 4=RRX (5-7 pass a through)
//   req_a, req_amt, req_cin operand, shift amount 0-255, carry in
//   sh_a, sh_shamt          barrel shifter operand and amount
//   sh_left/shift/arith     barrel shifter mode controls
//   sh_y                    barrel shifter result
//   rsp_valid/rsp_ready     response handshake
//   rsp_y, rsp_cout         shift result and carry-out
//   dbg_state               current FSM state (0=IDLE 1=SHIFT 2=DONE)
module shifter_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [7:0]  req_amt,
  input  logic        req_cin,
  output logic [31:0] sh_a,
  output logic [4:0]  sh_shamt,
  output logic        sh_left,
  output logic        sh_shift,
  output logic        sh_arith,
  input  logic [31:0] sh_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_y,
  output logic        rsp_cout,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_LSL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_RRX = 3'd4;

  state_t      state;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [7:0]  amt_q;
  logic        cin_q;

  assign dbg_state = state;

  // Barrel controls derived from the incoming request. They are loaded into
  // the sh_* registers at accept time.
  logic       ctl_left, ctl_shift, ctl_arith;
  logic [4:0] ctl_shamt;
  logic       req_in_range;

  assign req_in_range = (req_amt != 8'd0) && (req_amt[7:5] == 3'd0);

  always_comb begin
    ctl_left  = 1'b0;
    ctl_shift = 1'b0;
    ctl_arith = 1'b0;
    ctl_shamt = 5'd0;
    case (req_op)
      OP_LSL: begin
        ctl_left  = 1'b1;
        ctl_shift = 1'b1;
        ctl_shamt = req_in_range ? req_amt[4:0] : 5'd0;
      end
      OP_LSR: begin
        ctl_shift = 1'b1;
        ctl_shamt = req_in_range ? req_amt[4:0] : 5'd0;
      end
      OP_ASR: begin
        ctl_shift = 1'b1;
        ctl_arith = 1'b1;
        ctl_shamt = req_in_range ? req_amt[4:0] : 5'd0;
      end
      // Rotation is modulo 32, so the low bits are always the right amount.
      OP_ROR:  ctl_shamt = req_amt[4:0];
      OP_RRX:  ctl_shamt = 5'd1;
      default: ctl_shamt = 5'd0;
    endcase
  end

  // Result selection from the stored request plus the shifter output.
  logic [31:0] res_y;
  logic        res_cout;
  logic        amt_zero, amt_small;
  logic [4:0]  idx_left;   // 32-amt, for LSL carry
  logic [4:0]  idx_right;  // amt-1, for right-shift carry

  assign amt_zero  = (amt_q == 8'd0);
  assign amt_small = (amt_q[7:5] == 3'd0);
  assign idx_left  = 5'd0 - amt_q[4:0];
  assign idx_right = amt_q[4:0] - 5'd1;

  always_comb begin
    res_y    = a_q;
    res_cout = cin_q;
    case (op_q)
      OP_LSL: begin
        if (amt_zero) begin
          res_y = a_q; res_cout = cin_q;
        end else if (amt_small) begin
          res_y = sh_y; res_cout = a_q[idx_left];
        end else if (amt_q == 8'd32) begin
          res_y = 32'd0; res_cout = a_q[0];
        end else begin
          res_y = 32'd0; res_cout = 1'b0;
        end
      end
      OP_LSR: begin
        if (amt_zero) begin
          res_y = a_q; res_cout = cin_q;
        end else if (amt_small) begin
          res_y = sh_y; res_cout = a_q[idx_right];
        end else if (amt_q == 8'd32) begin
          res_y = 32'd0; res_cout = a_q[31];
        end else begin
          res_y = 32'd0; res_cout = 1'b0;
        end
      end
      OP_ASR: begin
        if (amt_zero) begin
          res_y = a_q; res_cout = cin_q;
        end else if (amt_small) begin
          res_y = sh_y; res_cout = a_q[idx_right];
        end else begin
          res_y = {32{a_q[31]}}; res_cout = a_q[31];
        end
      end
      OP_ROR: begin
        if (amt_zero) begin
          res_y = a_q; res_cout = cin_q;
        end else if (amt_q[4:0] == 5'd0) begin
          // A whole number of full rotations leaves a unchanged.
          res_y = a_q; res_cout = a_q[31];
        end else begin
          res_y = sh_y; res_cout = a_q[idx_right];
        end
      end
      OP_RRX: begin
        // The shifter does ROR 1; the old carry replaces the wrapped bit.
        res_y    = {cin_q, sh_y[30:0]};
        res_cout = a_q[0];
      end
      default: begin
        res_y = a_q; res_cout = cin_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_y     <= 32'd0;
      rsp_cout  <= 1'b0;
      op_q      <= 3'd0;
      a_q       <= 32'd0;
      amt_q     <= 8'd0;
      cin_q     <= 1'b0;
      sh_a      <= 32'd0;
      sh_shamt  <= 5'd0;
      sh_left   <= 1'b0;
      sh_shift  <= 1'b0;
      sh_arith  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            a_q       <= req_a;
            amt_q     <= req_amt;
            cin_q     <= req_cin;
            sh_a      <= req_a;
            sh_shamt  <= ctl_shamt;
            sh_left   <= ctl_left;
            sh_shift  <= ctl_shift;
            sh_arith  <= ctl_arith;
            req_ready <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          rsp_y     <= res_y;
          rsp_cout  <= res_cout;
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_ctrl.sv
module tb_shifter_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [7:0]  req_amt;
  logic        req_cin;
  logic [31:0] sh_a;
  logic [4:0]  sh_shamt;
  logic        sh_left, sh_shift, sh_arith;
  logic [31:0] sh_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_y;
  logic        rsp_cout;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  shifter_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_amt(req_amt), .req_cin(req_cin),
    .sh_a(sh_a), .sh_shamt(sh_shamt),
    .sh_left(sh_left), .sh_shift(sh_shift), .sh_arith(sh_arith),
    .sh_y(sh_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_cout(rsp_cout),
    .dbg_state(dbg_state)
  );

  // Behavioural barrel shifter sitting outside the DUT.
  function automatic logic [31:0] barrel(input logic [31:0] a, input logic [4:0] s,
                                         input logic l, input logic sh, input logic ar);
    logic [31:0] r;
    if (sh) begin
      if (l)       r = a << s;
      else if (ar) r = $signed(a) >>> s;
      else         r = a >> s;
    end else begin
      r = (s == 5'd0) ? a : ((a >> s) | (a << (6'd32 - {1'b0, s})));
    end
    return r;
  endfunction

  always_comb sh_y = barrel(sh_a, sh_shamt, sh_left, sh_shift, sh_arith);

  // Reference model for the random run: wide shifts instead of case rules.
  task automatic ref_shift(input logic [2:0] op, input logic [31:0] a, input logic [7:0] amt,
                           input logic cin, output logic [31:0] y, output logic c);
    logic [63:0] t;
    logic [4:0]  r;
    y = a; c = cin;
    if (op == 3'd4) begin
      y = {cin, a[31:1]}; c = a[0];
    end else if (op <= 3'd3 && amt != 8'd0) begin
      case (op)
        3'd0: begin t = {32'd0, a} << amt; y = t[31:0]; c = t[32]; end
        3'd1: begin t = {a, 32'd0} >> amt; y = t[63:32]; c = t[31]; end
        3'd2: begin t = $signed({a, 32'd0}) >>> amt; y = t[63:32]; c = t[31]; end
        default: begin
          r = amt[4:0];
          y = (r == 5'd0) ? a : ((a >> r) | (a << (6'd32 - {1'b0, r})));
          c = y[31];
        end
      endcase
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One full transaction: accept, sample sh_* in SHIFT, collect result.
  // lat counts cycles from the accept cycle to the first rsp_valid cycle.
  task automatic run_txn(input logic [2:0] op, input logic [31:0] a, input logic [7:0] amt,
                         input logic cin, output logic [31:0] y, output logic c,
                         output logic [31:0] s_a, output logic [4:0] s_amt,
                         output logic [2:0] s_ctl, output int lat);
    int waits;
    waits = 0;
    y = '0; c = 1'b0; s_a = '0; s_amt = '0; s_ctl = '0; lat = 0;
    while (!req_ready && waits < 10) begin
      @(negedge clk); waits++;
    end
    if (!req_ready) check("req_ready_timeout", 0, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_amt = amt; req_cin = cin;
    @(negedge clk);
    req_valid = 1'b0;
    s_a = sh_a; s_amt = sh_shamt; s_ctl = {sh_left, sh_shift, sh_arith};
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    if (!rsp_valid) check("rsp_valid_timeout", 0, 1);
    y = rsp_y; c = rsp_cout;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [7:0]  amt;
    logic        cin;
    logic [31:0] exp_y;
    logic        exp_c;
    logic [4:0]  exp_shamt;
    logic [2:0]  exp_ctl;   // {left, shift, arith}
  } vec_t;

  vec_t vecs[19];

  logic [31:0] got_y, got_sa, ry, hold_y;
  logic        got_c, rc, hold_c;
  logic [4:0]  got_amt;
  logic [2:0]  got_ctl;
  int          lat;
  logic        bad;

  initial begin
    vecs[0]  = '{3'd0, 32'h8000_0001, 8'd1,   1'b0, 32'h0000_0002, 1'b1, 5'd1,  3'b110};
    vecs[1]  = '{3'd2, 32'h8000_0000, 8'd40,  1'b0, 32'hFFFF_FFFF, 1'b1, 5'd0,  3'b011};
    vecs[2]  = '{3'd1, 32'h8000_0000, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 5'd0,  3'b010};
    vecs[3]  = '{3'd1, 32'h8000_0000, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 5'd0,  3'b010};
    vecs[4]  = '{3'd3, 32'h1234_5678, 8'd32,  1'b1, 32'h1234_5678, 1'b0, 5'd0,  3'b000};
    vecs[5]  = '{3'd3, 32'h1234_5678, 8'd0,   1'b1, 32'h1234_5678, 1'b1, 5'd0,  3'b000};
    vecs[6]  = '{3'd4, 32'h0000_0003, 8'd0,   1'b1, 32'h8000_0001, 1'b1, 5'd1,  3'b000};
    vecs[7]  = '{3'd0, 32'h0000_0001, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 5'd0,  3'b110};
    vecs[8]  = '{3'd0, 32'hFFFF_FFFF, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 5'd0,  3'b110};
    vecs[9]  = '{3'd1, 32'h8000_0000, 8'd31,  1'b1, 32'h0000_0001, 1'b0, 5'd31, 3'b010};
    vecs[10] = '{3'd2, 32'h8000_0000, 8'd4,   1'b1, 32'hF800_0000, 1'b0, 5'd4,  3'b011};
    vecs[11] = '{3'd3, 32'h0000_0001, 8'd1,   1'b0, 32'h8000_0000, 1'b1, 5'd1,  3'b000};
    vecs[12] = '{3'd3, 32'h0000_000F, 8'd36,  1'b0, 32'hF000_0000, 1'b1, 5'd4,  3'b000};
    vecs[13] = '{3'd5, 32'hA5A5_A5A5, 8'd3,   1'b1, 32'hA5A5_A5A5, 1'b1, 5'd0,  3'b000};
    vecs[14] = '{3'd0, 32'h0000_00F0, 8'd0,   1'b0, 32'h0000_00F0, 1'b0, 5'd0,  3'b110};
    vecs[15] = '{3'd4, 32'h0000_0002, 8'd200, 1'b0, 32'h0000_0001, 1'b0, 5'd1,  3'b000};
    vecs[16] = '{3'd2, 32'h7FFF_FFFF, 8'd255, 1'b1, 32'h0000_0000, 1'b0, 5'd0,  3'b011};
    vecs[17] = '{3'd0, 32'h4000_0000, 8'd2,   1'b0, 32'h0000_0000, 1'b1, 5'd2,  3'b110};
    vecs[18] = '{3'd3, 32'h8000_0000, 8'd64,  1'b0, 32'h8000_0000, 1'b1, 5'd0,  3'b000};

    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_amt = '0;
    req_cin = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_y", {rsp_cout, rsp_y}, 0);
    check("rst_sh", {sh_a, sh_shamt, sh_left, sh_shift, sh_arith}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);

    // Idle with no request: nothing moves
    repeat (3) @(negedge clk);
    check("idle_hold", {req_ready, rsp_valid, sh_a}, {1'b1, 1'b0, 32'd0});

    // Directed vector table
    for (int i = 0; i < 19; i++) begin
      run_txn(vecs[i].op, vecs[i].a, vecs[i].amt, vecs[i].cin,
              got_y, got_c, got_sa, got_amt, got_ctl, lat);
      check($sformatf("vec%0d_y", i), got_y, vecs[i].exp_y);
      check($sformatf("vec%0d_cout", i), got_c, vecs[i].exp_c);
      check($sformatf("vec%0d_shamt", i), got_amt, vecs[i].exp_shamt);
      check($sformatf("vec%0d_ctl", i), got_ctl, vecs[i].exp_ctl);
      check($sformatf("vec%0d_sh_a", i), got_sa, vecs[i].a);
      check($sformatf("vec%0d_latency", i), lat, 2);
    end

    // Back-pressure in DONE: result held, new requests ignored
    req_valid = 1'b1; req_op = 3'd1; req_a = 32'hF0F0_0000; req_amt = 8'd4; req_cin = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("bp_in_done", rsp_valid, 1);
    hold_y = rsp_y; hold_c = rsp_cout;
    check("bp_value", {hold_c, hold_y}, {1'b0, 32'h0F0F_0000});
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_op = 3'd0; req_a = 32'hDEAD_BEEF; req_amt = 8'd7;
      @(negedge clk);
      if (rsp_y !== hold_y || rsp_cout !== hold_c || req_ready !== 1'b0 || rsp_valid !== 1'b1)
        bad = 1'b1;
    end
    check("bp_stable", bad, 0);
    check("bp_sh_a_kept", sh_a, 32'hF0F0_0000);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_release_idle", {req_ready, rsp_valid}, 2'b10);

    // Reset while in SHIFT
    req_valid = 1'b1; req_op = 3'd0; req_a = 32'hFFFF_FFFF; req_amt = 8'd3; req_cin = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_in_shift", sh_a, 32'hFFFF_FFFF);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_sh", {sh_a, sh_shamt, sh_left, sh_shift, sh_arith}, 0);
    check("mid_rst_rsp", {rsp_valid, rsp_cout, rsp_y}, 0);
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad = 1'b1;
    end
    check("mid_rst_no_rsp", bad, 0);
    check("mid_rst_ready", req_ready, 1);

    // Random transactions against the reference model
    bad = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [7:0]  amt;
      logic        cin;
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      amt = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 33)) : 8'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      run_txn(op, a, amt, cin, got_y, got_c, got_sa, got_amt, got_ctl, lat);
      ref_shift(op, a, amt, cin, ry, rc);
      if (got_y !== ry || got_c !== rc || lat != 2) begin
        if (!bad)
          $display("FAIL rand_first op=%0d a=%h amt=%0d cin=%0d: got %h/%0d lat %0d expected %h/%0d lat 2",
                   op, a, amt, cin, got_y, got_c, lat, ry, rc);
        bad = 1'b1;
      end
    end
    check("random_10k", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
